ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter; the send direction paired with the existing PS/2 receive decoder on the mouse port.
- Sends one command byte to the attached PS/2 device, for example 0xF4 "enable data reporting" or 0xFF "reset".
- Drives the clock and data lines open-collector style through active-high pull-low enables.
- Runs alongside the receiver on the same ps2_clk/ps2_data pins and reports completion, device NACK or timeout to the mouse interface logic.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_filter.sv | 53 +++++
 rtl/ps2_host_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Definitions shared by the PS/2 host transmitter and the receive decoder:
// the transmitter state encoding, common device command/response bytes and
// the PS/2 odd-parity helper.
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REL,
        SHIFT,
        ACK,
        WAITIDLE
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;  // enable data reporting
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;  // device reset
    localparam logic [7:0] PS2_ACK        = 8'hFA;  // device acknowledge byte

    // PS/2 frames carry odd parity: the parity bit makes the total count of
    // ones across data and parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Two-flop synchroniser followed by a glitch filter for one PS/2 line.
// A new level is accepted only after FILTER_LEN consecutive synchronised
// samples agree on it. Shared by the transmitter and the receive decoder.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset (line assumed idle/high)
//   raw    in   asynchronous pin level
//   level  out  filtered line level
//   fall   out  one-cycle strobe when level goes 1->0 (aligned with level)
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int            CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;    // consecutive samples disagreeing with level

    // NOTE: every register here is updated with non-blocking assignments so
    // all flops sample the values from before the edge, like real hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
                fall  <= level;     // only a 1->0 change raises the strobe
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Inhibits the bus, presents a start bit,
// then shifts out 8 data bits (LSB first), odd parity and stop on the device
// clock's falling edges, and checks the device's ACK bit.
// Lines are driven open-collector style: *_oe = 1 pulls the line low.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   tx_data         command byte, captured when tx_start is accepted
//   tx_start        request strobe, accepted only while busy = 0
//   busy            high from acceptance until the bus is idle again
//   done            one-cycle pulse: device ACKed the byte
//   error           one-cycle pulse: device NACK or timeout
//   ps2_clk_in      raw PS/2 clock pin
//   ps2_data_in     raw PS/2 data pin
//   ps2_clk_oe      1 = pull PS/2 clock low
//   ps2_data_oe     1 = pull PS/2 data low
//
// Build option: define PS2_TX_INIT_EN to send PS2_CMD_ENABLE automatically
// 4*INHIBIT_CYCLES cycles after reset is released.
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int TIMEOUT_CYCLES = 220000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int            IW          = $clog2(INHIBIT_CYCLES);
    localparam int            TW          = $clog2(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] INH_PRELAST = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    logic clk_level, clk_fall;
    logic data_level;
    logic data_fall_unused;     // data edges carry no meaning for the sender

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_data_in),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    ps2_state_t    state;
    logic [7:0]    byte_q;
    logic          parity;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    bit_idx;

    logic       start_req;
    logic [7:0] start_byte;

`ifdef PS2_TX_INIT_EN
    localparam int            INIT_CYCLES = 4 * INHIBIT_CYCLES;
    localparam int            NW          = $clog2(INIT_CYCLES);
    localparam logic [NW-1:0] INIT_LAST   = NW'(INIT_CYCLES - 1);

    logic [NW-1:0] init_cnt;
    logic          init_pending;    // start-up command not yet accepted
    logic          init_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt     <= '0;
            init_pending <= 1'b1;
        end else if (init_pending) begin
            if (init_cnt != INIT_LAST)
                init_cnt <= init_cnt + NW'(1);
            else if (state == IDLE)
                init_pending <= 1'b0;
        end
    end

    // The internal request takes priority, so a simultaneous external
    // tx_start is dropped like any other request arriving while busy.
    assign init_fire  = init_pending && (init_cnt == INIT_LAST) && (state == IDLE);
    assign start_req  = init_fire | tx_start;
    assign start_byte = init_fire ? PS2_CMD_ENABLE : tx_data;
`else
    assign start_req  = tx_start;
    assign start_byte = tx_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            byte_q      <= '0;
            parity      <= 1'b0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            bit_idx     <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        byte_q     <= start_byte;
                        parity     <= odd_parity(start_byte);
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        inh_cnt    <= '0;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    inh_cnt <= inh_cnt + IW'(1);
                    // Decided one edge early so the start bit is on the line
                    // during the final inhibit cycle.
                    if (inh_cnt == INH_PRELAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= REL;
                    end
                end
                REL: begin
                    ps2_clk_oe <= 1'b0;
                    bit_idx    <= '0;
                    tmo_cnt    <= '0;
                    state      <= SHIFT;
                end
                SHIFT, ACK: begin
                    // A fall in the same cycle as expiry wins over the timeout.
                    if (clk_fall) begin
                        tmo_cnt <= '0;
                        if (state == ACK) begin
                            if (data_level)
                                error <= 1'b1;
                            else
                                done  <= 1'b1;
                            state <= WAITIDLE;
                        end else begin
                            if (bit_idx != 4'hF)
                                bit_idx <= bit_idx + 4'd1;
                            if (bit_idx < 4'd8) begin
                                ps2_data_oe <= ~byte_q[bit_idx[2:0]];
                            end else if (bit_idx == 4'd8) begin
                                ps2_data_oe <= ~parity;
                            end else begin
                                ps2_data_oe <= 1'b0;   // stop bit: release
                                state       <= ACK;
                            end
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        error       <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                WAITIDLE: begin
                    if (clk_level && data_level) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Drives ps2_host_tx against a behavioural PS/2 device that generates the
// bus clock, captures the host's frame on rising edges and ACKs or NACKs.
// Expected frames are built from the byte value alone (start 0, data LSB
// first, odd parity, stop 1).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 60;
    localparam int TIMEOUT = 1000;
    localparam int FILT    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       busy, done, error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    // Wired-AND bus: either side pulling low wins.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FILTER_LEN     (FILT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int last_fall = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done)          done_cnt <= done_cnt + 1;
        if (error)         err_cnt  <= err_cnt + 1;
        if (done && error) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Odd parity from a population count.
    function automatic logic odd_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 0;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_tx(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_rise", 32'(busy), 1);
    endtask

    // Measures how long the host holds the clock low and when the start bit
    // appears (1-based cycle within the inhibit window).
    task automatic check_inhibit();
        int hi = 0;
        int first = 0;
        while (ps2_clk_oe && hi < INHIBIT + 20) begin
            hi++;
            if (ps2_data_oe && first == 0) first = hi;
            @(negedge clk);
        end
        check("inhibit_len", 32'(hi), INHIBIT);
        check("start_bit_cycle", 32'(first), INHIBIT);
    endtask

    // Device side: issues up to `falls` clock pulses for the ten frame bits,
    // sampling the data line at each rising edge, then the ACK pulse.
    task automatic device_clock(input int half, input int falls, input bit nack,
                                input bit inject, output logic [10:0] frame);
        frame = '0;
        wait_cycles(20);
        frame[0] = ps2_data_in;
        for (int k = 0; k < 10; k++) begin
            if (k == falls) return;
            dev_clk_low = 1'b1;
            last_fall   = cyc;
            if (inject && k == 4) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                check("busy_mid", 32'(busy), 1);
                wait_cycles(half - 1);
            end else begin
                wait_cycles(half);
            end
            frame[k+1]  = ps2_data_in;
            dev_clk_low = 1'b0;
            wait_cycles(half);
        end
        if (!nack) dev_data_low = 1'b1;
        wait_cycles(10);
        dev_clk_low = 1'b1;
        wait_cycles(half);
        dev_clk_low = 1'b0;
        wait_cycles(5);
        dev_data_low = 1'b0;
    endtask

    task automatic do_tx(input logic [7:0] b, input int half, input bit nack, input bit inject);
        int d0, e0, n;
        logic [10:0] fr;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(b);
        check_inhibit();
        device_clock(half, 10, nack, inject, fr);
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("busy_drop", 32'(busy), 0);
        check("start_bit", 32'(fr[0]), 0);
        check($sformatf("data_%02h", b), 32'(fr[8:1]), 32'(b));
        check($sformatf("parity_%02h", b), 32'(fr[9]), 32'(odd_par(b)));
        check("stop_bit", 32'(fr[10]), 1);
        check($sformatf("done_pulses_%02h", b), 32'(done_cnt - d0), nack ? 0 : 1);
        check($sformatf("error_pulses_%02h", b), 32'(err_cnt - e0), nack ? 1 : 0);
    endtask

    initial begin
        int d0, e0, n, elapsed;
        logic [10:0] fr;

        reset = 1'b1;
        wait_cycles(5);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        reset = 1'b0;
        wait_cycles(5);

        do_tx(8'hF4, 40, 1'b0, 1'b0);   // enable data reporting, ACKed
        do_tx(8'hFF, 35, 1'b0, 1'b0);   // all ones, parity bit 1
        do_tx(8'h5A, 40, 1'b1, 1'b0);   // NACK
        do_tx(8'hC3, 45, 1'b0, 1'b1);   // second request mid-transfer ignored

        // Device stops clocking after bit 3.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hA5);
        check_inhibit();
        device_clock(40, 4, 1'b0, 1'b0, fr);
        n = 0;
        while (!error && n < TIMEOUT + 100) begin
            n++;
            @(negedge clk);
        end
        elapsed = cyc - last_fall;
        check("tmo_seen", 32'(error), 1);
        check("tmo_window", 32'(elapsed >= TIMEOUT && elapsed <= TIMEOUT + 12), 1);
        check("tmo_clk_oe", 32'(ps2_clk_oe), 0);
        check("tmo_data_oe", 32'(ps2_data_oe), 0);
        check("tmo_busy", 32'(busy), 0);
        wait_cycles(2);
        check("tmo_done_pulses", 32'(done_cnt - d0), 0);
        check("tmo_error_pulses", 32'(err_cnt - e0), 1);
        wait_cycles(20);

        // Reset in the middle of the data bits, then a clean transfer.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h2C);
        check_inhibit();
        device_clock(40, 5, 1'b0, 1'b0, fr);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_mid_data_oe", 32'(ps2_data_oe), 0);
        check("rst_mid_busy", 32'(busy), 0);
        reset = 1'b0;
        wait_cycles(20);
        check("rst_mid_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
        do_tx(8'hF3, 40, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            do_tx(8'($urandom), int'($urandom_range(25, 50)),
                  $urandom_range(0, 3) == 0, 1'b0);
            wait_cycles(int'($urandom_range(1, 10)));
        end

        check("done_error_overlap", 32'(both_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
